// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared widths, peak result record and complex power helper
package xcorr_pkg;
  localparam int PWR_W = 24;
  localparam int EXP_W = 8;
  localparam int SMP_W = 12;
  localparam int IDX_MAX_W = 16;
  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic [PWR_W-1:0] pwr;
    logic [EXP_W-1:0] exp;
    logic det;
    logic err;
  } peak_res_t;
  function automatic logic [PWR_W-1:0] sq(input logic signed [SMP_W-1:0] x);
    logic signed [2*SMP_W-1:0] p;
    p = x * x;
    return PWR_W'(unsigned'(p));
  endfunction
  // (-2048)^2 * 2 = 2^23 fits in 24 bits, so the sum never wraps
  function automatic logic [PWR_W-1:0] cpx_pwr(input logic signed [SMP_W-1:0] i, input logic signed [SMP_W-1:0] q);
    return sq(i) + sq(q);
  endfunction
endpackage

// File: rtl/xcorr_fft_peak_rx_cpx_pwr.sv
// xcorr_cpx_pwr: two-stage registered I^2+Q^2 with valid and tag passthrough
module xcorr_cpx_pwr
  import xcorr_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ival,
  input  logic signed [SMP_W-1:0] idata_i,
  input  logic signed [SMP_W-1:0] idata_q,
  input  logic [TAG_W-1:0]        itag,
  output logic                    oval,
  output logic [PWR_W-1:0]        opwr,
  output logic [TAG_W-1:0]        otag
);
  logic v1;
  logic [PWR_W-1:0] sq_i, sq_q;
  logic [TAG_W-1:0] t1;
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      oval <= 1'b0;
    end else begin
      v1 <= ival;
      oval <= v1;
    end
    sq_i <= sq(idata_i);
    sq_q <= sq(idata_q);
    t1 <= itag;
    opwr <= sq_i + sq_q;
    otag <= t1;
  end
endmodule

// File: rtl/xcorr_fft_peak_rx.sv
// xcorr_fft_peak_rx: per-frame max-power bin search with length/exponent checks
module xcorr_fft_peak_rx
  import xcorr_pkg::*;
#(
  parameter int NFFT = 1024,
  parameter int IDX_W = $clog2(NFFT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ival,
  input  logic signed [SMP_W-1:0] idata_i,
  input  logic signed [SMP_W-1:0] idata_q,
  input  logic [EXP_W-1:0]        iexp,
  input  logic                    ieop,
  input  logic [PWR_W-1:0]        ithr,
  output logic [IDX_W-1:0]        opeak_idx,
  output logic [PWR_W-1:0]        opeak_pwr,
  output logic [EXP_W-1:0]        oexp,
  output logic                    odet,
  output logic                    oerr,
  output logic                    oval
);
  localparam int TAG_W = IDX_W + 3 + EXP_W;
  logic [IDX_W-1:0] cnt;
  logic [EXP_W-1:0] frame_exp;
  logic first, wrap, last, bin_err;
  assign first = cnt == '0;
  assign wrap = cnt == IDX_W'(NFFT - 1);
  assign last = ieop | wrap;
  // a frame closes on eop or at the last bin; anything but eop exactly there is a length error
  assign bin_err = (last & ~(ieop & wrap)) | (~first & (iexp != frame_exp));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      frame_exp <= '0;
    end else if (ival) begin
      cnt <= last ? '0 : cnt + 1'b1;
      frame_exp <= first ? iexp : frame_exp;
    end
  end
  logic p_val, p_first, p_last, p_err;
  logic [PWR_W-1:0] p_pwr;
  logic [IDX_W-1:0] p_idx;
  logic [EXP_W-1:0] p_exp;
  logic [TAG_W-1:0] p_tag;
  xcorr_cpx_pwr #(.TAG_W(TAG_W)) u_pwr (
    .clk(clk),
    .rst(rst),
    .ival(ival),
    .idata_i(idata_i),
    .idata_q(idata_q),
    .itag({cnt, first, last, bin_err, iexp}),
    .oval(p_val),
    .opwr(p_pwr),
    .otag(p_tag)
  );
  assign {p_idx, p_first, p_last, p_err, p_exp} = p_tag;
  logic [PWR_W-1:0] mx, n_pwr;
  logic [IDX_W-1:0] mx_idx, n_idx;
  logic [EXP_W-1:0] mx_exp, n_exp;
  logic mx_err, n_err, take;
  // the first bin of a frame always reloads the max so nothing leaks across frames
  always_comb begin
    take = p_first | (p_pwr > mx);
    n_pwr = take ? p_pwr : mx;
    n_idx = take ? p_idx : mx_idx;
    n_exp = p_first ? p_exp : mx_exp;
    n_err = p_err | (~p_first & mx_err);
  end
  peak_res_t res;
  always_ff @(posedge clk) begin
    if (rst) begin
      mx <= '0;
      mx_idx <= '0;
      mx_exp <= '0;
      mx_err <= 1'b0;
      res <= '0;
      oval <= 1'b0;
    end else begin
      oval <= p_val & p_last;
      if (p_val) begin
        mx <= n_pwr;
        mx_idx <= n_idx;
        mx_exp <= n_exp;
        mx_err <= n_err;
        if (p_last) res <= '{idx: IDX_MAX_W'(n_idx), pwr: n_pwr, exp: n_exp, det: n_pwr > ithr, err: n_err};
      end
    end
  end
  logic unused_idx_hi;
  assign unused_idx_hi = |(res.idx >> IDX_W);
  assign opeak_idx = res.idx[IDX_W-1:0];
  assign opeak_pwr = res.pwr;
  assign oexp = res.exp;
  assign odet = res.det;
  assign oerr = res.err;
endmodule

// File: tb/tb_xcorr_fft_peak_rx.sv
// tb_xcorr_fft_peak_rx: directed frames, scoreboard queue checked by an oval monitor
module tb_xcorr_fft_peak_rx;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst, ival, ieop, odet, oerr, oval;
  logic signed [11:0] idata_i, idata_q;
  logic [7:0] iexp, oexp;
  logic [23:0] ithr, opeak_pwr;
  logic [3:0] opeak_idx;
  always #5 clk = ~clk;
  xcorr_fft_peak_rx #(.NFFT(N)) dut (
    .clk(clk), .rst(rst), .ival(ival), .idata_i(idata_i), .idata_q(idata_q),
    .iexp(iexp), .ieop(ieop), .ithr(ithr), .opeak_idx(opeak_idx),
    .opeak_pwr(opeak_pwr), .oexp(oexp), .odet(odet), .oerr(oerr), .oval(oval)
  );
  typedef struct {int idx; int pwr; int ex; int det; int err; int due;} exp_t;
  exp_t sb[$];
  int cyc = 0, pass_n = 0, tot_n = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int req);
    tot_n++;
    if (act == req) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (oval) begin
      if (sb.size() == 0) chk("spurious_oval", 1, 0);
      else begin
        e = sb.pop_front();
        chk("idx", int'(opeak_idx), e.idx);
        chk("pwr", int'(opeak_pwr), e.pwr);
        chk("exp", int'(oexp), e.ex);
        chk("det", int'(odet), e.det);
        chk("err", int'(oerr), e.err);
        chk("latency", cyc, e.due);
      end
    end
  end
  task automatic bin(input int i, input int q, input int e, input bit eop);
    ival = 1'b1;
    idata_i = 12'(i);
    idata_q = 12'(q);
    iexp = 8'(e);
    ieop = eop;
    @(posedge clk);
    #1;
    ival = 1'b0;
    ieop = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic frame(input int n, input bit eop, input int p1, input int p2, input int pi, input int pq,
                       input int bi, input int bq, input int e, input int chg, input int e2,
                       input bit gaps, input bit push, input exp_t x);
    exp_t y;
    for (int b = 0; b < n; b++) begin
      if (gaps && b > 0) idle($urandom_range(0, 2));
      if (push && b == n - 1) begin
        y = x;
        y.due = cyc + 3;
        sb.push_back(y);
      end
      bin((b == p1 || b == p2) ? pi : bi, (b == p1 || b == p2) ? pq : bq,
          (chg >= 0 && b >= chg) ? e2 : e, eop && b == n - 1);
    end
  endtask
  initial begin
    rst = 1'b1; ival = 1'b0; ieop = 1'b0; idata_i = '0; idata_q = '0; iexp = '0; ithr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idx", int'(opeak_idx), 0);
    chk("rst_pwr", int'(opeak_pwr), 0);
    chk("rst_exp", int'(oexp), 0);
    chk("rst_det", int'(odet), 0);
    chk("rst_err", int'(oerr), 0);
    chk("rst_oval", int'(oval), 0);
    idle(4);
    ithr = 24'd10000;
    frame(16, 1, 9, -1, 100, -50, 1, 1, 5, -1, 0, 0, 1, '{9, 12500, 5, 1, 0, 0});
    idle(4);
    ithr = 24'd8388608;
    frame(16, 1, 3, 12, -2048, -2048, 0, 0, 0, -1, 0, 0, 1, '{3, 8388608, 0, 0, 0, 0});
    idle(4);
    ithr = 24'd50;
    frame(16, 1, 2, -1, 10, 0, 0, 0, 7, -1, 0, 0, 1, '{2, 100, 7, 1, 0, 0});
    frame(16, 1, 14, -1, 7, 0, 1, 1, 7, -1, 0, 1, 1, '{14, 49, 7, 0, 0, 0});
    idle(4);
    frame(8, 1, 7, -1, 7, 0, 1, 1, 1, -1, 0, 0, 1, '{7, 49, 1, 0, 1, 0});
    idle(4);
    ithr = 24'd10;
    frame(16, 0, 0, -1, 0, 5, 1, 0, 2, -1, 0, 0, 1, '{0, 25, 2, 1, 1, 0});
    frame(16, 1, 15, -1, 30, 40, 1, 0, 3, -1, 0, 0, 1, '{15, 2500, 3, 1, 0, 0});
    idle(4);
    ithr = 24'd100;
    frame(16, 1, 5, -1, 0, 9, 0, 0, 4, 5, 6, 0, 1, '{5, 81, 4, 0, 1, 0});
    idle(4);
    frame(8, 0, 3, -1, 50, 50, 0, 0, 9, -1, 0, 0, 0, '{0, 0, 0, 0, 0, 0});
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    ithr = 24'd0;
    frame(16, 1, 11, -1, -3, -3, 1, -1, 9, -1, 0, 0, 1, '{11, 18, 9, 1, 0, 0});
    idle(8);
    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/xcorr_fft_peak_rx.md
Name: xcorr_fft_peak_rx

Overview:
- Consumes the frame stream produced by the FFT correlator stage: 12-bit I/Q bins, an 8-bit block exponent, a valid strobe and an end-of-frame strobe.
- For each frame it computes per-bin power I²+Q², finds the maximum-power bin and checks frame length.
- At end of frame it reports peak index, peak power, block exponent and a detection flag against a runtime threshold.
- Sits between the FFT correlator output and the modem's timing-acquisition logic.

Parameters:
- NFFT, 1024, expected bins per frame; power of two, 16..65536.
- IDX_W, $clog2(NFFT), width of bin index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ival  in  1  bin valid; gaps allowed
- idata_i  in  12  signed I of bin
- idata_q  in  12  signed Q of bin
- iexp  in  8  block exponent of current frame
- ieop  in  1  last bin of frame; qualified by ival
- ithr  in  24  unsigned power threshold
- opeak_idx  out  IDX_W  index of max-power bin
- opeak_pwr  out  24  power of that bin
- oexp  out  8  exponent captured at first bin of frame
- odet  out  1  opeak_pwr > ithr (strict)
- oerr  out  1  frame-length or exponent error for this frame
- oval  out  1  one-cycle result strobe

Behaviour:
- Reset (synchronous, active-high, clk edge): all outputs 0; bin counter 0; running max cleared; pipeline valids cleared; a partially received frame is discarded.
- Bin counter:
  - increments on each ival.
  - Returns to 0 after a bin with ieop=1, or after bin NFFT-1.
  - Bin with counter==0 is the frame's first bin.
- Power: pwr = I*I + Q*Q as unsigned 24 bits. Max is (-2048)²·2 = 8388608, so there is no overflow and no saturation.
- Pipeline (carries valid, index, first, last):
  - S1 registers the two squares.
  - S2 registers the sum.
  - S3 updates the running max.
  - Result registers load in the cycle after S3 sees last.
- Latency: the ieop bin accepted at cycle T gives oval=1 at cycle T+3, exactly one cycle. Throughput is 1 bin/cycle. A new frame's first bin may arrive at T+1.
- Running max:
  - The first bin of a frame loads max unconditionally.
  - Later bins replace it only if pwr > max (strict), so on ties the earliest bin wins.
  - On a first+last overlap the new frame's first bin wins.
- Exponent: iexp is sampled at the first bin. Any later bin in the same frame with a different iexp sets that frame's error flag.
- Length check:
  - ieop with counter != NFFT-1 (short frame): result emitted normally, oerr=1.
  - Bin NFFT-1 without ieop (long/missing eop): frame is force-closed and its result emitted with oerr=1; the next bin starts a new frame.
  - A single-bin frame (ieop on first bin) is legal input: idx 0, pwr of that bin, oerr=1 unless NFFT==1 (not supported).
- odet is computed from ithr sampled in the same cycle the results load.
- opeak_idx, opeak_pwr, oexp, odet and oerr hold between oval pulses.
- ival=0 cycles freeze the counter; pipeline bubbles propagate and no state is altered.

Decomposition:
- Package xcorr_pkg:
  - PWR_W=24, EXP_W=8, SMP_W=12.
  - typedef struct peak_res_t {idx, pwr, exp, det, err}.
  - Function cpx_pwr (I²+Q²).
- One sub-module, xcorr_cpx_pwr: two-stage registered I²+Q² with valid/tag passthrough, reusable elsewhere in the modem.
- Peak tracking, counter and length check stay in the top module.

Test Plan (NFFT=16):
- Reset/idle: rst for 3 cycles, no ival → all outputs 0 and oval never asserts.
- Single clean frame: 16 bins, all (1,1) except bin 9 = (100,-50), iexp=5, ieop on bin 15, ithr=10000.
  - Expect oval 3 cycles after ieop.
  - idx=9, pwr=12500, oexp=5, odet=1, oerr=0.
- Tie, extreme value, and threshold not exceeded:
  - Bins 3 and 12 both (-2048,-2048), rest 0, ithr=8388608.
  - Expect idx=3, pwr=8388608, odet=0 (strict compare).
- Back-to-back with gaps:
  - Frame A (peak at 2) immediately followed by frame B (peak at 14), random ival gaps inside B.
  - Expect two oval pulses with idx 2 then 14; no cross-frame leakage of the max.
- Length errors:
  - Frame with ieop on bin 7 → oerr=1, peak over bins 0..7 only.
  - Frame with no ieop → forced close after bin 15, oerr=1; the following frame is reported correctly with oerr=0.
- Exponent change and mid-frame reset:
  - iexp changes 4→6 at bin 5 → oerr=1, oexp=4.
  - rst asserted at bin 8 of a frame → no oval for it; the next full frame reports correctly.
